regfile_ctrl: RTL and testbench

- Controller in front of the Raisin64 two-read/one-write register file.
- Shares the single write port between NUM_SRC writeback sources (ALU, load unit, mul/div) using a round-robin arbiter, and drives a registered write port.
- Keeps a 64-entry pending-write scoreboard. Issue stalls on RAW and WAW hazards until the owning writeback reaches the register file.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/rr_arbiter.sv | 44 ++++
 rtl/regfile_ctrl.sv | 110 +++++++++++
 tb/tb_regfile_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the Raisin64 register file controller.
package regfile_pkg;

    localparam int REG_BITS = 6;
    localparam int DATA_W   = 64;
    localparam int NUM_REGS = 64;
    localparam int ZERO_REG = 0;

    typedef logic [REG_BITS-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0]   reg_data_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, pointer advances past the winner.
module rr_arbiter #(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    logic [IDX_W-1:0] ptr;
    int               scan;

    // Scan from the pointer upward, wrapping, and take the first requester.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        scan      = 0;
        for (int k = 0; k < N; k++) begin
            scan = int'(ptr) + k;
            if (scan >= N) begin
                scan = scan - N;
            end
            if (!grant_any && req[scan]) begin
                grant[scan] = 1'b1;
                grant_idx   = IDX_W'(scan);
                grant_any   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Register file controller: write-port arbitration, pending-write scoreboard and issue stall.
// Optional macro REGCTRL_WB_BYPASS_EN lets issue proceed past a register being written this cycle.
module regfile_ctrl #(
    parameter int NUM_SRC  = 3,
    parameter int DATA_W   = 64,
    parameter int REG_BITS = 6
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_SRC-1:0]           wb_valid,
    output logic [NUM_SRC-1:0]           wb_ready,
    input  logic [NUM_SRC*REG_BITS-1:0]  wb_rn,
    input  logic [NUM_SRC*DATA_W-1:0]    wb_data,
    output logic                         w_en,
    output logic [REG_BITS-1:0]          w_rn,
    output logic [DATA_W-1:0]            w_data,
    input  logic                         iss_valid,
    output logic                         iss_ready,
    input  logic [REG_BITS-1:0]          iss_rs1,
    input  logic [REG_BITS-1:0]          iss_rs2,
    input  logic [REG_BITS-1:0]          iss_rd,
    input  logic                         iss_has_rd,
    output logic                         sb_err
);

    import regfile_pkg::*;

    localparam int SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int NREGS = 2 ** REG_BITS;

    logic [NUM_SRC-1:0]  grant;
    logic [SRC_W-1:0]    grant_idx;
    logic                grant_any;
    logic [REG_BITS-1:0] sel_rn;
    logic [DATA_W-1:0]   sel_data;
    logic [NREGS-1:0]    pending;
    logic [NREGS-1:0]    busy;
    logic [NREGS-1:0]    clr_vec;
    logic [NREGS-1:0]    set_vec;
    logic                iss_stall;
    logic                iss_fire;

    rr_arbiter #(
        .N     (NUM_SRC),
        .IDX_W (SRC_W)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (wb_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    assign wb_ready = grant;
    assign sel_rn   = wb_rn[grant_idx*REG_BITS +: REG_BITS];
    assign sel_data = wb_data[grant_idx*DATA_W +: DATA_W];

    // A grant to r0 is consumed by the arbiter but never reaches the register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_en   <= 1'b0;
            w_rn   <= '0;
            w_data <= '0;
        end else if (grant_any && int'(sel_rn) != ZERO_REG) begin
            w_en   <= 1'b1;
            w_rn   <= sel_rn;
            w_data <= sel_data;
        end else begin
            w_en   <= 1'b0;
        end
    end

    always_comb begin
        busy    = pending;
`ifdef REGCTRL_WB_BYPASS_EN
        if (w_en) begin
            busy[w_rn] = 1'b0;
        end
`endif
        busy[0] = 1'b0;
    end

    assign iss_stall = iss_valid & (busy[iss_rs1] | busy[iss_rs2] | (iss_has_rd & busy[iss_rd]));
    assign iss_ready = ~iss_stall;
    assign iss_fire  = iss_valid & iss_ready;

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        if (w_en) begin
            clr_vec[w_rn] = 1'b1;
        end
        if (iss_fire && iss_has_rd && int'(iss_rd) != ZERO_REG) begin
            set_vec[iss_rd] = 1'b1;
        end
    end

    // Set is applied after clear so a same-cycle reissue of the written register stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            sb_err  <= 1'b0;
        end else begin
            pending <= ((pending & ~clr_vec) | set_vec) & {{(NREGS-1){1'b1}}, 1'b0};
            sb_err  <= sb_err | (w_en & ~pending[w_rn]);
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: directed steps then randomized traffic against a reference model.
// Honours REGCTRL_WB_BYPASS_EN when the design is built with it.
module tb_regfile_ctrl;

    localparam int N  = 3;
    localparam int DW = 64;
    localparam int RB = 6;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    wb_valid;
    logic [N-1:0]    wb_ready;
    logic [N*RB-1:0] wb_rn;
    logic [N*DW-1:0] wb_data;
    logic            w_en;
    logic [RB-1:0]   w_rn;
    logic [DW-1:0]   w_data;
    logic            iss_valid;
    logic            iss_ready;
    logic [RB-1:0]   iss_rs1;
    logic [RB-1:0]   iss_rs2;
    logic [RB-1:0]   iss_rd;
    logic            iss_has_rd;
    logic            sb_err;

    always #5 clk = ~clk;

    regfile_ctrl #(
        .NUM_SRC  (N),
        .DATA_W   (DW),
        .REG_BITS (RB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_valid   (wb_valid),
        .wb_ready   (wb_ready),
        .wb_rn      (wb_rn),
        .wb_data    (wb_data),
        .w_en       (w_en),
        .w_rn       (w_rn),
        .w_data     (w_data),
        .iss_valid  (iss_valid),
        .iss_ready  (iss_ready),
        .iss_rs1    (iss_rs1),
        .iss_rs2    (iss_rs2),
        .iss_rd     (iss_rd),
        .iss_has_rd (iss_has_rd),
        .sb_err     (sb_err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: set of registers with a write in flight, rotation start, expected write port.
    bit          m_pend[64];
    bit          claimed[64];
    int          m_ptr;
    bit          m_wen;
    logic [5:0]  m_wrn;
    logic [63:0] m_wdata;
    bit          m_err;

`ifdef REGCTRL_WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int modelGrant();
        for (int k = 0; k < N; k++) begin
            if (wb_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic bit modelP(input logic [5:0] x);
        if (x == 6'd0) return 1'b0;
        if (BYPASS && m_wen && m_wrn == x) return 1'b0;
        return m_pend[x];
    endfunction

    function automatic bit modelIssReady();
        return !(iss_valid && (modelP(iss_rs1) || modelP(iss_rs2) || (iss_has_rd && modelP(iss_rd))));
    endfunction

    task automatic modelReset();
        for (int r = 0; r < 64; r++) begin
            m_pend[r]  = 1'b0;
            claimed[r] = 1'b0;
        end
        m_ptr   = 0;
        m_wen   = 1'b0;
        m_wrn   = '0;
        m_wdata = '0;
        m_err   = 1'b0;
    endtask

    task automatic modelEdge();
        int         g;
        bit         fire;
        logic [5:0] rn;
        g    = modelGrant();
        fire = iss_valid && modelIssReady();
        if (m_wen) begin
            if (!m_pend[m_wrn]) m_err = 1'b1;
            m_pend[m_wrn]  = 1'b0;
            claimed[m_wrn] = 1'b0;
        end
        if (fire && iss_has_rd && iss_rd != 6'd0) m_pend[iss_rd] = 1'b1;
        if (g >= 0) begin
            m_ptr = (g + 1) % N;
            rn    = wb_rn[g*RB +: RB];
            if (rn != 6'd0) begin
                m_wen       = 1'b1;
                m_wrn       = rn;
                m_wdata     = wb_data[g*DW +: DW];
                claimed[rn] = 1'b1;
            end else begin
                m_wen = 1'b0;
            end
        end else begin
            m_wen = 1'b0;
        end
    endtask

    task automatic checkAll(input string tag);
        int       g;
        logic [2:0] eg;
        g  = modelGrant();
        eg = (g < 0) ? 3'b000 : 3'(1 << g);
        checkOutput({tag, ".wb_ready"}, 64'(wb_ready), 64'(eg));
        checkOutput({tag, ".iss_ready"}, 64'(iss_ready), 64'(modelIssReady()));
        checkOutput({tag, ".w_en"}, 64'(w_en), 64'(m_wen));
        checkOutput({tag, ".w_rn"}, 64'(w_rn), 64'(m_wrn));
        checkOutput({tag, ".w_data"}, w_data, m_wdata);
        checkOutput({tag, ".sb_err"}, 64'(sb_err), 64'(m_err));
    endtask

    task automatic applyStimulus(input logic [2:0] v, input logic [17:0] rns, input logic [191:0] datas,
                                 input logic iv, input logic [5:0] rs1, input logic [5:0] rs2,
                                 input logic [5:0] rd, input logic hrd);
        wb_valid   = v;
        wb_rn      = rns;
        wb_data    = datas;
        iss_valid  = iv;
        iss_rs1    = rs1;
        iss_rs2    = rs2;
        iss_rd     = rd;
        iss_has_rd = hrd;
    endtask

    task automatic step(input string tag);
        #1 checkAll(tag);
        @(posedge clk);
        if (rst_n) modelEdge();
        @(negedge clk);
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        modelReset();
        #1 checkAll("rst");
        @(negedge clk);
        checkOutput("rst.w_en_held", 64'(w_en), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [17:0]  rns;
        logic [191:0] datas;
        logic [2:0]   v;
        int           cand[$];

        rst_n = 1'b1;
        modelReset();
        applyStimulus(3'b111, {6'd3, 6'd2, 6'd1}, {64'hC, 64'hB, 64'hA}, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        @(negedge clk);

        // Arbitration rotation from reset with all sources requesting.
        doReset();
        for (int c = 0; c < 4; c++) begin
            #1 checkOutput($sformatf("arb.c%0d.grant", c), 64'(wb_ready), 64'(1 << (c % 3)));
            checkOutput($sformatf("arb.c%0d.w_en", c), 64'(w_en), 64'(c >= 1));
            step($sformatf("arb.c%0d", c));
        end
        applyStimulus(3'b000, '0, '0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        step("arb.idle");
        doReset();

        // Issue rd=5, dependent rs1=5 stalls until the write to r5 lands.
        applyStimulus(3'b000, '0, '0, 1'b1, 6'd0, 6'd0, 6'd5, 1'b1);
        step("raw.issue_rd");
        applyStimulus(3'b000, '0, '0, 1'b1, 6'd5, 6'd0, 6'd0, 1'b0);
        #1 checkOutput("raw.stall", 64'(iss_ready), 64'd0);
        step("raw.wait");
        applyStimulus(3'b001, {6'd0, 6'd0, 6'd5}, {64'd0, 64'd0, 64'hDEAD}, 1'b1, 6'd5, 6'd0, 6'd0, 1'b0);
        step("raw.wb");
        applyStimulus(3'b000, '0, '0, 1'b1, 6'd5, 6'd0, 6'd0, 1'b0);
        #1 checkOutput("raw.w_en", 64'(w_en), 64'd1);
        checkOutput("raw.w_rn", 64'(w_rn), 64'd5);
        checkOutput("raw.w_data", w_data, 64'hDEAD);
        checkOutput("raw.ready_on_write", 64'(iss_ready), 64'(BYPASS));
        step("raw.write");
        #1 checkOutput("raw.ready_after", 64'(iss_ready), 64'd1);
        step("raw.after");

        // Writeback to r0 consumes the grant without writing.
        applyStimulus(3'b010, {6'd0, 6'd0, 6'd0}, {64'd3, 64'd2, 64'd1}, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        #1 checkOutput("r0.grant", 64'(wb_ready), 64'b010);
        step("r0.wb");
        applyStimulus(3'b101, {6'd0, 6'd0, 6'd0}, {64'd3, 64'd2, 64'd1}, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        #1 checkOutput("r0.ptr_adv", 64'(wb_ready), 64'b100);
        checkOutput("r0.no_write", 64'(w_en), 64'd0);
        step("r0.next");
        applyStimulus(3'b000, '0, '0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        #1 checkOutput("r0.sb_err", 64'(sb_err), 64'd0);
        step("r0.idle");

        // Reissue rd=7 in the same cycle r7 is written.
        applyStimulus(3'b000, '0, '0, 1'b1, 6'd0, 6'd0, 6'd7, 1'b1);
        step("waw.issue");
        applyStimulus(3'b001, {6'd0, 6'd0, 6'd7}, {64'd0, 64'd0, 64'h77}, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        step("waw.wb");
        applyStimulus(3'b000, '0, '0, 1'b1, 6'd0, 6'd0, 6'd7, 1'b1);
        #1 checkOutput("waw.ready", 64'(iss_ready), 64'(BYPASS));
        step("waw.reissue");
        applyStimulus(3'b000, '0, '0, 1'b1, 6'd7, 6'd0, 6'd0, 1'b0);
        #1 checkOutput("waw.pending_kept", 64'(iss_ready), 64'(!BYPASS));
        checkOutput("waw.sb_err", 64'(sb_err), 64'd0);
        step("waw.probe");

        // Write to a non-pending register raises a sticky error.
        applyStimulus(3'b001, {6'd0, 6'd0, 6'd9}, {64'd0, 64'd0, 64'h99}, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        step("err.wb");
        applyStimulus(3'b000, '0, '0, 1'b0, 6'd0, 6'd0, 6'd0, 1'b0);
        step("err.write");
        #1 checkOutput("err.set", 64'(sb_err), 64'd1);
        applyStimulus(3'b110, {6'd0, 6'd0, 6'd0}, {64'd0, 64'd0, 64'd0}, 1'b1, 6'd3, 6'd4, 6'd0, 1'b0);
        step("err.traffic1");
        step("err.traffic2");
        #1 checkOutput("err.sticky", 64'(sb_err), 64'd1);
        doReset();
        #1 checkOutput("err.cleared", 64'(sb_err), 64'd0);

        // Randomized traffic; sources only write back registers that are pending and not yet granted.
        for (int c = 0; c < 400; c++) begin
            if (c == 200) doReset();
            v = '0;
            rns = '0;
            datas = '0;
            for (int s = 0; s < N; s++) begin
                cand.delete();
                for (int r = 1; r < 64; r++) begin
                    if (m_pend[r] && !claimed[r]) cand.push_back(r);
                end
                if ($urandom_range(9) == 0) begin
                    v[s] = 1'b1;
                    rns[s*RB +: RB] = 6'd0;
                end else if (cand.size() > 0 && $urandom_range(3) != 0) begin
                    v[s] = 1'b1;
                    rns[s*RB +: RB] = 6'(cand[$urandom_range(cand.size() - 1)]);
                end
                datas[s*DW +: DW] = {$urandom, $urandom};
            end
            applyStimulus(v, rns, datas, 1'($urandom_range(1)), 6'($urandom_range(15)),
                          6'($urandom_range(15)), 6'($urandom_range(15)), 1'($urandom_range(1)));
            step($sformatf("rnd.c%0d", c));
        end
        #1 checkOutput("rnd.no_err", 64'(sb_err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
